// File: rtl/bit_char_pkg.sv
// bit_char_pkg: shared character constants, FSM states and bit-position bounds
package bit_char_pkg;
  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_ONE  = 8'h31;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [3:0] POS_FIRST = 4'd1;
  localparam logic [3:0] POS_LAST  = 4'd8;
  typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;
endpackage

// File: rtl/bit_char_tx.sv
// bit_char_tx: serialises a byte into eight ASCII bit characters plus optional LF
module bit_char_tx
  import bit_char_pkg::*;
#(
  parameter bit LSB_FIRST    = 1'b1,
  parameter bit EMIT_NEWLINE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic [3:0] addr_out,
  output logic       busy
);
  localparam logic [3:0] START = LSB_FIRST ? POS_FIRST : POS_LAST;
  localparam logic [3:0] STOP  = LSB_FIRST ? POS_LAST : POS_FIRST;
  state_t     state, state_n;
  logic [3:0] pos, pos_n;
  logic [7:0] data, data_n;
  logic [7:0] char_n;
  assign byte_ready = (state == IDLE);
  // next state, position and hold register; outputs are precomputed from the next state so they can be registered
  always_comb begin
    state_n = state;
    pos_n   = pos;
    data_n  = data;
    unique case (state)
      IDLE: if (byte_valid) begin
        state_n = SEND;
        pos_n   = START;
        data_n  = byte_in;
      end
      SEND: if (char_ready) begin
        if (pos == STOP) state_n = EMIT_NEWLINE ? TERM : IDLE;
        else pos_n = LSB_FIRST ? pos + 4'd1 : pos - 4'd1;
      end
      TERM: if (char_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    char_n = (state_n == SEND) ? (data_n[pos_n[2:0] - 3'd1] ? CHAR_ONE : CHAR_ZERO) :
             (state_n == TERM) ? CHAR_LF : 8'h00;
  end
  // state and registered outputs; position 8 maps to bit 7 via 3-bit wraparound
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pos        <= '0;
      data       <= '0;
      char_out   <= '0;
      char_valid <= 1'b0;
      addr_out   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      pos        <= pos_n;
      data       <= data_n;
      char_out   <= char_n;
      char_valid <= (state_n != IDLE);
      addr_out   <= (state_n == SEND) ? pos_n : 4'd0;
      busy       <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_bit_char_tx.sv
// tb_bit_char_tx: three parameter variants driven in parallel against a character-queue model
module tb_bit_char_tx;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       char_ready = 1'b1;
  logic       br [3];
  logic       cv [3];
  logic       bz [3];
  logic [7:0] co [3];
  logic [3:0] ao [3];
  int checks = 0;
  int failures = 0;
  localparam logic [2:0] LSB = 3'b101;
  localparam logic [2:0] NL  = 3'b011;
  logic [11:0] seq [3][9];
  int n [3];
  int idx [3];
  bit rst_seen = 1'b0;
  always #5 clk = ~clk;
  bit_char_tx #(.LSB_FIRST(1'b1), .EMIT_NEWLINE(1'b1)) d0 (.clk(clk), .reset(reset), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(br[0]), .char_out(co[0]), .char_valid(cv[0]),
    .char_ready(char_ready), .addr_out(ao[0]), .busy(bz[0]));
  bit_char_tx #(.LSB_FIRST(1'b0), .EMIT_NEWLINE(1'b1)) d1 (.clk(clk), .reset(reset), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(br[1]), .char_out(co[1]), .char_valid(cv[1]),
    .char_ready(char_ready), .addr_out(ao[1]), .busy(bz[1]));
  bit_char_tx #(.LSB_FIRST(1'b1), .EMIT_NEWLINE(1'b0)) d2 (.clk(clk), .reset(reset), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(br[2]), .char_out(co[2]), .char_valid(cv[2]),
    .char_ready(char_ready), .addr_out(ao[2]), .busy(bz[2]));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_edge();
    rst_seen = !reset;
    for (int d = 0; d < 3; d++) begin
      if (!reset) begin
        n[d] = 0;
        idx[d] = 0;
      end else if (idx[d] == n[d]) begin
        if (byte_valid) begin
          for (int k = 0; k < 8; k++) begin
            int b;
            b = LSB[d] ? k : 7 - k;
            seq[d][k] = {byte_in[b] ? 8'h31 : 8'h30, 4'(b + 1)};
          end
          seq[d][8] = {8'h0A, 4'd0};
          n[d] = NL[d] ? 9 : 8;
          idx[d] = 0;
        end
      end else if (char_ready) idx[d]++;
    end
  endtask
  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      bit empty;
      empty = (idx[d] == n[d]);
      chk($sformatf("byte_ready[%0d]", d), int'(br[d]), int'(empty));
      chk($sformatf("char_valid[%0d]", d), int'(cv[d]), int'(!empty));
      chk($sformatf("busy[%0d]", d), int'(bz[d]), int'(!empty));
      if (!empty) begin
        chk($sformatf("char_out[%0d]", d), int'(co[d]), int'(seq[d][idx[d]][11:4]));
        chk($sformatf("addr_out[%0d]", d), int'(ao[d]), int'(seq[d][idx[d]][3:0]));
      end
      if (rst_seen) begin
        chk($sformatf("rst_char_out[%0d]", d), int'(co[d]), 0);
        chk($sformatf("rst_addr_out[%0d]", d), int'(ao[d]), 0);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  initial begin
    for (int d = 0; d < 3; d++) begin
      n[d] = 0;
      idx[d] = 0;
    end
    steps(2);
    reset = 1'b1;
    step();
    byte_valid = 1'b1;
    byte_in = 8'h01;
    step();
    byte_valid = 1'b0;
    steps(12);
    byte_valid = 1'b1;
    byte_in = 8'hA5;
    step();
    byte_valid = 1'b0;
    steps(3);
    char_ready = 1'b0;
    steps(3);
    char_ready = 1'b1;
    steps(10);
    byte_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      byte_in = 8'($urandom);
      step();
    end
    byte_valid = 1'b0;
    steps(10);
    byte_valid = 1'b1;
    byte_in = 8'h5C;
    step();
    byte_valid = 1'b0;
    steps(4);
    reset = 1'b0;
    step();
    reset = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'hFF;
    step();
    byte_valid = 1'b0;
    steps(11);
    byte_valid = 1'b1;
    byte_in = 8'h00;
    step();
    byte_in = 8'hFF;
    steps(20);
    byte_valid = 1'b0;
    steps(10);
    for (int i = 0; i < 1500; i++) begin
      byte_valid = 1'($urandom_range(0, 1));
      byte_in = 8'($urandom);
      char_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 199) != 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bit_char_tx.md
# bit_char_tx

Transmit-side counterpart of the message memory: takes one byte at a time over a valid/ready handshake. Emits it as a stream of eight ASCII bit characters, `"0"` (8'h30) or `"1"` (8'h31), one per accepted output beat, with an optional line-feed terminator after each byte. Each character carries a 1-based bit-position tag, `addr_out` = 1..8, which names bit `addr_out - 1` of the source byte. This is the same indexing the receive-side memory uses, so the stream round-trips through it.

## Interface
- `LSB_FIRST`, default 1: 1 = bit 0 sent first (`addr_out` 1→8); 0 = bit 7 sent first (`addr_out` 8→1).
- `EMIT_NEWLINE`, default 1: 1 = append 8'h0A after the 8th character; 0 = no terminator.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-low: 0 at a rising edge resets the block.
- `byte_in`: input, 8 bits. Byte to transmit; sampled on input handshake.
- `byte_valid`: input, 1 bit. Producer has a byte.
- `byte_ready`: output, 1 bit. Block can accept a byte.
- `char_out`: output, 8 bits. Current ASCII character.
- `char_valid`: output, 1 bit. `char_out` and `addr_out` are valid.
- `char_ready`: input, 1 bit. Consumer takes the character.
- `addr_out`: output, 4 bits. Bit position 1..8 of the current character; 0 for the terminator.
- `busy`: output, 1 bit. High while not IDLE.

## Operation
- FSM states:
  - IDLE: `byte_ready`=1, `char_valid`=0.
  - SEND: emitting the 8 bit characters.
  - TERM: emitting the LF terminator.
- Input handshake: `byte_valid && byte_ready` at an edge captures `byte_in` into a shift/hold register. On that edge the FSM goes to SEND with position counter = 1, or 8 if `LSB_FIRST`=0.
- In SEND: `char_out` = (captured bit [`addr_out`-1]) ? 8'h31 : 8'h30.
- Output handshake: `char_valid && char_ready` at an edge advances the position: +1 if `LSB_FIRST`, else −1.
  - When the last position (8, or 1 if MSB-first) is handshaken, the FSM goes to TERM if `EMIT_NEWLINE`, else IDLE.
- In TERM: `char_out`=8'h0A, `addr_out`=0. Its handshake returns the FSM to IDLE.
- Backpressure: while `char_valid`=1 and `char_ready`=0, `char_out` and `addr_out` hold stable. The captured byte is unaffected by `byte_in` changes.
- `byte_valid` outside IDLE is ignored (`byte_ready`=0). No byte is lost or double-captured.
- `byte_in` bits are used as-is; there is no ASCII interpretation on input.
- Position counter is 4 bits; values outside 1..8 are never reached in SEND.

## Timing
- Reset (`reset`=0 at an edge) forces, from the next cycle:
  - state IDLE, `char_valid`=0, `char_out`=8'h00, `addr_out`=0, `busy`=0, `byte_ready`=1, captured byte=0.
- Reset mid-operation abandons the byte; no terminator is sent. Reset has priority over both handshakes in the same cycle.
- Latency: the first character is valid in the cycle after input acceptance.
- Registers: `char_out`, `char_valid`, `addr_out` and `busy` are registered. `byte_ready` = (state == IDLE).
- Throughput with `char_ready` held at 1: 8 or 9 character cycles per byte plus one IDLE cycle. Back-to-back bytes therefore take 10 cycles each with `EMIT_NEWLINE`=1, or 9 with `EMIT_NEWLINE`=0.
- There is no combinational path from `char_ready` to any output.

## Structure
- Shared package `bit_char_pkg` holds:
  - `CHAR_ZERO`=8'h30, `CHAR_ONE`=8'h31, `CHAR_LF`=8'h0A;
  - the FSM state enum (IDLE/SEND/TERM);
  - `POS_FIRST`/`POS_LAST` helper constants.
  - The receive-side memory imports the same character constants.
- Single module; no sub-module. The position counter and FSM are small enough to stay inline.

## Test plan
- **LSB-first with terminator:** defaults, `char_ready`=1, send 8'h01 → `char_out` "10000000" then 8'h0A. `addr_out` runs 1,2,…,8,0. `byte_ready` is 1 again on the cycle after the LF handshake.
- **MSB-first:** `LSB_FIRST`=0, send 8'h01 → "00000001\n", `addr_out` runs 8,7,…,1,0.
- **Backpressure:** during byte 8'hA5, drop `char_ready` for 3 cycles at position 4 → `char_out`=8'h30 and `addr_out`=4 stay stable. Then the stream resumes with no characters skipped or repeated.
- **Busy-time input ignored:** hold `byte_valid`=1 with `byte_in` toggling during transmission → `byte_ready`=0 throughout. Only the first byte is sent; the next capture happens only after return to IDLE.
- **Reset mid-byte:** after 4 characters, drive `reset`=0 for one edge → next cycle `char_valid`=0, `char_out`=8'h00, `byte_ready`=1. A new byte 8'hFF then produces "11111111\n" starting at `addr_out`=1.
- **Back-to-back, no terminator:** `EMIT_NEWLINE`=0, `byte_valid` held with 8'h00 then 8'hFF → "00000000" then "11111111". Exactly one idle cycle between them, and no 8'h0A is emitted.
